// File: rtl/frame_addr_pkg.sv
// Shared types and helpers for the frame address sequencer: FSM states,
// the shadow window configuration and the window validation check.
package frame_addr_pkg;

  // Field width of the shadow configuration; wide enough for any frame size
  // this block is used with. The top truncates to its own XW/YW widths.
  localparam int CFG_FW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [CFG_FW-1:0] x0;
    logic [CFG_FW-1:0] y0;
    logic [CFG_FW-1:0] w;
    logic [CFG_FW-1:0] h;
    logic [1:0]        step;
    logic              mirror;
  } frame_cfg_t;

  // A window is usable when it is non-empty, fits inside the stored frame and
  // uses a supported decimation. Sums are one bit wider so they cannot wrap.
  function automatic logic cfg_valid(input frame_cfg_t cfg,
                                     input int         img_w,
                                     input int         img_h,
                                     input int         max_step);
    logic [CFG_FW:0] x_end;
    logic [CFG_FW:0] y_end;
    x_end = {1'b0, cfg.x0} + {1'b0, cfg.w};
    y_end = {1'b0, cfg.y0} + {1'b0, cfg.h};
    return (cfg.w != {CFG_FW{1'b0}}) &&
           (cfg.h != {CFG_FW{1'b0}}) &&
           (32'(x_end) <= 32'(img_w)) &&
           (32'(y_end) <= 32'(img_h)) &&
           (32'(cfg.step) <= 32'(max_step));
  endfunction

  // Whole-frame window used when the requested window is rejected.
  function automatic frame_cfg_t full_frame_cfg(input int img_w, input int img_h);
    frame_cfg_t c;
    c.x0     = {CFG_FW{1'b0}};
    c.y0     = {CFG_FW{1'b0}};
    c.w      = CFG_FW'(img_w);
    c.h      = CFG_FW'(img_h);
    c.step   = 2'd0;
    c.mirror = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/frame_addr_sequencer_axis_counter.sv
// Step counter for one axis of the window. Start, limit, step and direction
// are captured on load; the counter walks from start towards limit by step
// and returns to start (wrap) when advanced while sitting on the limit.
// It exposes its next value so the parent can register outputs in lockstep.
module axis_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_adv,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_limit,
  input  logic [W-1:0] i_step,
  input  logic         i_down,
  output logic [W-1:0] o_next,
  output logic         o_next_last,
  output logic         o_wrap
);

  logic [W-1:0] r_value;
  logic [W-1:0] r_start;
  logic [W-1:0] r_limit;
  logic [W-1:0] r_step;
  logic         r_down;
  logic         w_last;
  logic [W-1:0] w_next;

  assign w_last = (r_value == r_limit);
  assign o_next = w_next;
  assign o_wrap = i_adv & w_last & ~i_load;

  // Next position: reload, wrap to start, or step in the chosen direction.
  always_comb begin
    w_next = r_value;
    if (i_load) begin
      w_next = i_start;
    end else if (i_adv) begin
      if (w_last) begin
        w_next = r_start;
      end else if (r_down) begin
        w_next = r_value - r_step;
      end else begin
        w_next = r_value + r_step;
      end
    end else begin
      w_next = r_value;
    end
  end

  // Whether the next position is the final one of the axis.
  always_comb begin
    o_next_last = 1'b0;
    if (i_load) begin
      o_next_last = (i_start == i_limit);
    end else begin
      o_next_last = (w_next == r_limit);
    end
  end

  // Position register plus the per-frame shadow of start/limit/step/direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= {W{1'b0}};
      r_start <= {W{1'b0}};
      r_limit <= {W{1'b0}};
      r_step  <= {W{1'b0}};
      r_down  <= 1'b0;
    end else begin
      r_value <= w_next;
      if (i_load) begin
        r_start <= i_start;
        r_limit <= i_limit;
        r_step  <= i_step;
        r_down  <= i_down;
      end else begin
        r_start <= r_start;
        r_limit <= r_limit;
        r_step  <= r_step;
        r_down  <= r_down;
      end
    end
  end

endmodule

// File: rtl/frame_addr_sequencer.sv
// Frame buffer read address sequencer: walks a validated region of interest
// with power-of-two decimation and optional horizontal mirroring, presenting
// one address per cycle on a valid/ready interface with aligned frame flags.
module frame_addr_sequencer
  import frame_addr_pkg::*;
#(
  parameter int IMAGE_WIDTH   = 320,
  parameter int IMAGE_HEIGHT  = 240,
  parameter int ADDR_BITS     = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT),
  parameter int XW            = $clog2(IMAGE_WIDTH+1),
  parameter int YW            = $clog2(IMAGE_HEIGHT+1),
  parameter int MAX_STEP_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 resend,
  input  logic [XW-1:0]        cfg_x0,
  input  logic [YW-1:0]        cfg_y0,
  input  logic [XW-1:0]        cfg_w,
  input  logic [YW-1:0]        cfg_h,
  input  logic [1:0]           cfg_step,
  input  logic                 cfg_mirror,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [ADDR_BITS-1:0] rdaddress,
  output logic                 frame_start,
  output logic                 line_end,
  output logic                 frame_end,
  output logic                 cfg_err
);

  // Column arithmetic is widened by the step exponent and the row-base
  // arithmetic by one more bit, so a full decimation step never truncates.
  localparam int CW = XW + MAX_STEP_LOG2;
  localparam int RW = ADDR_BITS + MAX_STEP_LOG2 + 1;
  localparam logic [CW-1:0] C_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE   = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] R_PITCH = RW'(IMAGE_WIDTH);

  state_e               r_state;
  logic                 r_rd_valid;
  logic [ADDR_BITS-1:0] r_rdaddress;
  logic                 r_frame_start;
  logic                 r_line_end;
  logic                 r_frame_end;
  logic                 r_cfg_err;

  frame_cfg_t           w_raw;
  frame_cfg_t           w_cfg;
  logic                 w_ok;

  logic [CW-1:0]        w_x0;
  logic [CW-1:0]        w_col_span;
  logic [CW-1:0]        w_col_far;
  logic [CW-1:0]        w_col_first;
  logic [CW-1:0]        w_col_last;
  logic [CW-1:0]        w_col_step;
  logic [YW-1:0]        w_y0;
  logic [YW-1:0]        w_row_span;
  logic [YW-1:0]        w_row_far;
  logic [RW-1:0]        w_row_first;
  logic [RW-1:0]        w_row_last;
  logic [RW-1:0]        w_row_step;

  logic                 w_load;
  logic                 w_fire;
  logic                 w_col_adv;
  logic                 w_col_wrap;
  logic                 w_row_wrap;
  logic [CW-1:0]        w_col_next;
  logic                 w_col_next_last;
  logic [RW-1:0]        w_row_next;
  logic                 w_row_next_last;
  logic [ADDR_BITS-1:0] w_next_addr;
  logic                 w_next_le;
  logic                 w_next_fe;

  assign rd_valid    = r_rd_valid;
  assign rdaddress   = r_rdaddress;
  assign frame_start = r_frame_start;
  assign line_end    = r_line_end;
  assign frame_end   = r_frame_end;
  assign cfg_err     = r_cfg_err;

  // Assemble the requested window and substitute the full frame if invalid.
  always_comb begin
    w_raw        = full_frame_cfg(IMAGE_WIDTH, IMAGE_HEIGHT);
    w_raw.x0     = CFG_FW'(cfg_x0);
    w_raw.y0     = CFG_FW'(cfg_y0);
    w_raw.w      = CFG_FW'(cfg_w);
    w_raw.h      = CFG_FW'(cfg_h);
    w_raw.step   = cfg_step;
    w_raw.mirror = cfg_mirror;
    w_ok         = cfg_valid(w_raw, IMAGE_WIDTH, IMAGE_HEIGHT, MAX_STEP_LOG2);
    if (w_ok) begin
      w_cfg = w_raw;
    end else begin
      w_cfg = full_frame_cfg(IMAGE_WIDTH, IMAGE_HEIGHT);
    end
  end

  // Per-frame axis bounds; the row multiplies only feed the LOAD-time reload,
  // never the per-pixel step path.
  always_comb begin
    w_x0       = CW'(w_cfg.x0);
    w_col_span = CW'(w_cfg.w) - C_ONE;
    w_col_far  = w_x0 + ((w_col_span >> w_cfg.step) << w_cfg.step);
    w_col_step = C_ONE << w_cfg.step;
    if (w_cfg.mirror) begin
      w_col_first = w_col_far;
      w_col_last  = w_x0;
    end else begin
      w_col_first = w_x0;
      w_col_last  = w_col_far;
    end
    w_y0        = YW'(w_cfg.y0);
    w_row_span  = YW'(w_cfg.h) - Y_ONE;
    w_row_far   = w_y0 + ((w_row_span >> w_cfg.step) << w_cfg.step);
    w_row_first = RW'(32'(w_y0) * IMAGE_WIDTH);
    w_row_last  = RW'(32'(w_row_far) * IMAGE_WIDTH);
    w_row_step  = R_PITCH << w_cfg.step;
  end

  // Handshake and counter control; resend wins over a simultaneous transfer.
  always_comb begin
    w_load      = (r_state == LOAD);
    w_fire      = r_rd_valid & rd_ready;
    w_col_adv   = (r_state == RUN) & w_fire & ~resend;
    w_next_addr = ADDR_BITS'(w_row_next + RW'(w_col_next));
    w_next_le   = w_col_next_last;
    w_next_fe   = w_col_next_last & w_row_next_last;
  end

  axis_counter #(.W(CW)) u_col (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_adv       (w_col_adv),
    .i_start     (w_col_first),
    .i_limit     (w_col_last),
    .i_step      (w_col_step),
    .i_down      (w_cfg.mirror),
    .o_next      (w_col_next),
    .o_next_last (w_col_next_last),
    .o_wrap      (w_col_wrap)
  );

  // The row counter holds the row base address and steps once per line.
  axis_counter #(.W(RW)) u_row (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_adv       (w_col_wrap),
    .i_start     (w_row_first),
    .i_limit     (w_row_last),
    .i_step      (w_row_step),
    .i_down      (1'b0),
    .o_next      (w_row_next),
    .o_next_last (w_row_next_last),
    .o_wrap      (w_row_wrap)
  );

  // Sequencer FSM with registered address, flags and configuration status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rd_valid    <= 1'b0;
      r_rdaddress   <= {ADDR_BITS{1'b0}};
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
      r_frame_end   <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rd_valid    <= 1'b0;
          r_frame_start <= 1'b0;
          r_line_end    <= 1'b0;
          r_frame_end   <= 1'b0;
          r_state       <= enable ? LOAD : IDLE;
        end
        LOAD: begin
          r_cfg_err     <= ~w_ok;
          r_rd_valid    <= 1'b1;
          r_rdaddress   <= w_next_addr;
          r_frame_start <= 1'b1;
          r_line_end    <= w_next_le;
          r_frame_end   <= w_next_fe;
          r_state       <= RUN;
        end
        RUN: begin
          if (resend) begin
            // Pending address is dropped; the frame restarts from LOAD.
            r_rd_valid    <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_end   <= 1'b0;
            r_state       <= enable ? LOAD : IDLE;
          end else if (w_fire) begin
            if (w_row_wrap) begin
              r_rd_valid    <= 1'b0;
              r_frame_start <= 1'b0;
              r_line_end    <= 1'b0;
              r_frame_end   <= 1'b0;
              r_state       <= enable ? LOAD : IDLE;
            end else begin
              r_rdaddress   <= w_next_addr;
              r_frame_start <= 1'b0;
              r_line_end    <= w_next_le;
              r_frame_end   <= w_next_fe;
              r_state       <= RUN;
            end
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_rd_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_addr_sequencer.sv
// Directed bench for frame_addr_sequencer on an 8x4 frame. Expected address
// and flag tuples are pushed by a window model and popped on each transfer.
module tb_frame_addr_sequencer;

  localparam int IW = 8;
  localparam int IH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       resend;
  logic [3:0] cfg_x0;
  logic [2:0] cfg_y0;
  logic [3:0] cfg_w;
  logic [2:0] cfg_h;
  logic [1:0] cfg_step;
  logic       cfg_mirror;
  logic       rd_ready;
  logic       rd_valid;
  logic [4:0] rdaddress;
  logic       frame_start;
  logic       line_end;
  logic       frame_end;
  logic       cfg_err;

  typedef struct packed {
    logic [4:0] addr;
    logic       fs;
    logic       le;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  frame_addr_sequencer #(.IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .resend      (resend),
    .cfg_x0      (cfg_x0),
    .cfg_y0      (cfg_y0),
    .cfg_w       (cfg_w),
    .cfg_h       (cfg_h),
    .cfg_step    (cfg_step),
    .cfg_mirror  (cfg_mirror),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rdaddress   (rdaddress),
    .frame_start (frame_start),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h,
                         input int st, input int mir);
    cfg_x0     = 4'(x0);
    cfg_y0     = 3'(y0);
    cfg_w      = 4'(w);
    cfg_h      = 3'(h);
    cfg_step   = 2'(st);
    cfg_mirror = 1'(mir);
  endtask

  // Window model: list the emitted columns and rows, then enumerate addresses.
  task automatic push_window(input int x0, input int y0, input int w, input int h,
                             input int st, input int mir);
    int   cols[$];
    int   rows[$];
    int   stp;
    exp_t e;
    stp = 1 << st;
    for (int c = x0; c < x0 + w; c += stp) cols.push_back(c);
    if (mir != 0) cols.reverse();
    for (int r = y0; r < y0 + h; r += stp) rows.push_back(r);
    foreach (rows[j]) begin
      foreach (cols[k]) begin
        e.addr = 5'(rows[j] * IW + cols[k]);
        e.fs   = (j == 0) && (k == 0);
        e.le   = (k == cols.size() - 1);
        e.fe   = (k == cols.size() - 1) && (j == rows.size() - 1);
        q.push_back(e);
      end
    end
  endtask

  // Consume up to max_pops transfers; with rnd=0 rd_ready stays high and
  // every cycle must carry a valid address.
  task automatic drain(input bit rnd, input int max_pops, input int budget);
    int   cyc;
    int   pops;
    exp_t e;
    cyc  = 0;
    pops = 0;
    while (q.size() > 0 && pops < max_pops && cyc < budget) begin
      @(negedge clk);
      rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rnd) check("throughput_valid", 32'(rd_valid), 32'd1);
      if (rd_valid === 1'b1) begin
        e = q[0];
        check("rdaddress",   32'(rdaddress),   32'(e.addr));
        check("frame_start", 32'(frame_start), 32'(e.fs));
        check("line_end",    32'(line_end),    32'(e.le));
        check("frame_end",   32'(frame_end),   32'(e.fe));
        if (rd_ready) begin
          void'(q.pop_front());
          pops++;
        end
      end
      cyc++;
    end
    check("drain_complete", 32'(q.size() == 0 || pops >= max_pops), 32'd1);
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    resend   = 1'b0;
    rd_ready = 1'b0;
    set_cfg(0, 0, 8, 4, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_rd_valid",    32'(rd_valid),    32'd0);
    check("rst_rdaddress",   32'(rdaddress),   32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_line_end",    32'(line_end),    32'd0);
    check("rst_frame_end",   32'(frame_end),   32'd0);
    check("rst_cfg_err",     32'(cfg_err),     32'd0);

    // Full window, step 0: addresses 0..31 back to back.
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("load_bubble_first", 32'(rd_valid), 32'd0);
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b0, 1000, 100);

    // One LOAD bubble, then the cropped window 10,11,12,18,19,20.
    @(negedge clk);
    check("bubble_t1", 32'(rd_valid), 32'd0);
    check("cfg_err_t1", 32'(cfg_err), 32'd0);
    set_cfg(2, 1, 3, 2, 0, 0);
    push_window(2, 1, 3, 2, 0, 0);
    drain(1'b0, 1000, 50);

    // Step 1, then step 1 mirrored.
    @(negedge clk);
    check("bubble_t2", 32'(rd_valid), 32'd0);
    set_cfg(0, 0, 8, 4, 1, 0);
    push_window(0, 0, 8, 4, 1, 0);
    drain(1'b0, 1000, 50);
    @(negedge clk);
    check("bubble_t3a", 32'(rd_valid), 32'd0);
    set_cfg(0, 0, 8, 4, 1, 1);
    push_window(0, 0, 8, 4, 1, 1);
    drain(1'b0, 1000, 50);

    // Full frame with a random rd_ready pattern; stalls compare against the
    // same pending entry, so any drift during a stall is caught.
    @(negedge clk);
    check("bubble_t3b", 32'(rd_valid), 32'd0);
    set_cfg(0, 0, 8, 4, 0, 0);
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b1, 1000, 500);

    // Resend after the fifth accepted address, coinciding with a handshake.
    @(negedge clk);
    rd_ready = 1'b1;
    check("bubble_t4", 32'(rd_valid), 32'd0);
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b0, 5, 50);
    @(negedge clk);
    check("resend_pending_valid", 32'(rd_valid), 32'd1);
    check("resend_pending_addr", 32'(rdaddress), 32'd5);
    resend = 1'b1;
    @(negedge clk);
    resend = 1'b0;
    check("resend_bubble", 32'(rd_valid), 32'd0);
    q.delete();
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b0, 1000, 100);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    check("bubble_t5", 32'(rd_valid), 32'd0);
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b0, 3, 50);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_valid",    32'(rd_valid),    32'd0);
    check("arst_rdaddress",   32'(rdaddress),   32'd0);
    check("arst_frame_start", 32'(frame_start), 32'd0);
    check("arst_line_end",    32'(line_end),    32'd0);
    check("arst_frame_end",   32'(frame_end),   32'd0);
    check("arst_cfg_err",     32'(cfg_err),     32'd0);
    q.delete();

    // Invalid window (6+4 > 8) falls back to the full frame with cfg_err.
    set_cfg(6, 0, 4, 4, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("load_bubble_err", 32'(rd_valid), 32'd0);
    push_window(0, 0, 8, 4, 0, 0);
    drain(1'b0, 1000, 100);
    check("cfg_err_set", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check("bubble_t6", 32'(rd_valid), 32'd0);
    check("cfg_err_held", 32'(cfg_err), 32'd1);

    // Valid 1x1 window: cfg_err clears, all three flags on address 19.
    set_cfg(3, 2, 1, 1, 0, 0);
    push_window(3, 2, 1, 1, 0, 0);
    drain(1'b0, 1000, 20);
    check("cfg_err_clear", 32'(cfg_err), 32'd0);

    // Step 2 frame with enable dropped mid-frame: frame completes, then idle.
    @(negedge clk);
    check("bubble_t7", 32'(rd_valid), 32'd0);
    set_cfg(0, 0, 8, 4, 2, 0);
    push_window(0, 0, 8, 4, 2, 0);
    drain(1'b0, 2, 20);
    enable = 1'b0;
    drain(1'b0, 1000, 20);
    @(negedge clk);
    check("idle_after_frame", 32'(rd_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_stays", 32'(rd_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
